// File: rtl/bcd_pkg.sv
// Shared types, constants and helpers for the serial packed-BCD adder.
package bcd_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned BCD_MAX    = 9;
  localparam int unsigned BCD_ADJ    = 6;
  localparam int unsigned MAX_DIGITS = 16;
  localparam int unsigned MAX_W      = DIGIT_W * MAX_DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit i of a packed BCD vector; callers zero-extend to MAX_W.
  function automatic logic [DIGIT_W-1:0] get_digit(input logic [MAX_W-1:0] v,
                                                   input int unsigned i);
    return v[DIGIT_W*i +: DIGIT_W];
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder: binary add then +6 correction when the sum exceeds 9.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_d,
  input  logic [DIGIT_W-1:0] b_d,
  input  logic               c_in,
  output logic [DIGIT_W-1:0] d,
  output logic               c_out
);

  localparam int unsigned T_W = DIGIT_W + 1;

  logic [T_W-1:0] t;

  // Non-BCD digits go through the same rule; (t+6) mod 16 is the corrected digit.
  always_comb begin
    t     = T_W'(a_d) + T_W'(b_d) + T_W'(c_in);
    c_out = (t > T_W'(BCD_MAX));
    d     = c_out ? (t[DIGIT_W-1:0] + DIGIT_W'(BCD_ADJ)) : t[DIGIT_W-1:0];
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder time-sharing one digit adder, LSD first.
// Optional non-BCD input flag enabled by defining BCD_INPUT_CHECK_EN.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4  // legal range 2..16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DIGIT_W*DIGITS-1:0] a,
  input  logic [DIGIT_W*DIGITS-1:0] b,
  input  logic                    carry_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DIGIT_W*DIGITS-1:0] sum,
  output logic                    carry_out,
  output logic                    busy,
  output logic                    err
);

  localparam int unsigned W     = DIGIT_W * DIGITS;
  localparam int unsigned IDX_W = $clog2(DIGITS);
  localparam int unsigned LAST  = DIGITS - 1;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               carry_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;

  logic [DIGIT_W-1:0] a_d;
  logic [DIGIT_W-1:0] b_d;
  logic [DIGIT_W-1:0] d;
  logic               c_out;
  logic               accept_c;
  logic               last_c;

  assign a_d      = get_digit(MAX_W'(a_q), 32'(idx));
  assign b_d      = get_digit(MAX_W'(b_q), 32'(idx));
  assign accept_c = (state == IDLE) && in_valid && in_ready;
  assign last_c   = (idx == IDX_W'(LAST));

  bcd_digit_add u_digit (
    .a_d   (a_d),
    .b_d   (b_d),
    .c_in  (carry_q),
    .d     (d),
    .c_out (c_out)
  );

  // Sequencer: accept in IDLE, one digit per cycle in ADD, hold result in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept_c) begin
            a_q      <= a;
            b_q      <= b;
            carry_q  <= carry_in;
            sum      <= '0;
            idx      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ADD;
          end
        end
        ADD: begin
          sum[DIGIT_W*32'(idx) +: DIGIT_W] <= d;
          carry_q <= c_out;
          if (last_c) begin
            idx       <= '0;
            carry_out <= c_out;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BCD_INPUT_CHECK_EN
  logic bad_c;
  logic err_pend;

  always_comb begin
    bad_c = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if ((a[DIGIT_W*i +: DIGIT_W] > DIGIT_W'(BCD_MAX)) ||
          (b[DIGIT_W*i +: DIGIT_W] > DIGIT_W'(BCD_MAX)))
        bad_c = 1'b1;
    end
  end

  // Flag captured at accept, exposed only alongside out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_pend <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (accept_c)
        err_pend <= bad_c;
      if ((state == ADD) && last_c)
        err <= err_pend;
      else if ((state == DONE) && out_ready)
        err <= 1'b0;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Randomized and directed checks of bcd_serial_add_ctrl against a decimal reference model.
module tb_bcd_serial_add_ctrl;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;
`ifdef BCD_INPUT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         busy;
  logic         err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .busy      (busy),
    .err       (err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain decimal arithmetic on the operand values.
  function automatic longint unsigned bcd_val(input logic [W-1:0] v);
    longint unsigned r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      logic [W-1:0] t = v >> (4 * i);
      r = r * 10 + longint'(t[3:0]);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input longint unsigned x);
    logic [W-1:0] r = '0;
    longint unsigned v = x;
    for (int i = 0; i < DIGITS; i++) begin
      r = r | (W'(v % 10) << (4 * i));
      v = v / 10;
    end
    return r;
  endfunction

  task automatic ref_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                         output logic [W-1:0] s, output logic co);
    longint unsigned m   = 1;
    longint unsigned tot = bcd_val(av) + bcd_val(bv) + longint'(ci);
    for (int i = 0; i < DIGITS; i++) m = m * 10;
    co = (tot >= m);
    s  = to_bcd(tot % m);
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) r = r | (W'($urandom_range(0, 9)) << (4 * i));
    return r;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", 64'(in_ready), 64'(1));
  endtask

  // One transaction with out_ready held low for 'hold' extra DONE cycles.
  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                    input int hold, input logic [W-1:0] exp_s, input logic exp_c,
                    input logic exp_e);
    int lat = 0;
    logic [W-1:0] s0;
    logic c0;
    wait_ready();
    a = av; b = bv; carry_in = ci; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    check("accept_busy", 64'(busy), 64'(1));
    check("accept_in_ready", 64'(in_ready), 64'(0));
    // Extra requests while busy must be ignored.
    a = W'($urandom); b = W'($urandom); carry_in = ~ci;
    while (!out_valid && lat < int'(DIGITS) + 4) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(DIGITS));
    check("sum", 64'(sum), 64'(exp_s));
    check("carry_out", 64'(carry_out), 64'(exp_c));
    check("err", 64'(err), 64'(exp_e));
    s0 = sum; c0 = carry_out;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", 64'(out_valid), 64'(1));
      check("hold_sum", 64'(sum), 64'(s0));
      check("hold_carry", 64'(carry_out), 64'(c0));
      check("hold_in_ready", 64'(in_ready), 64'(0));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hs_out_valid", 64'(out_valid), 64'(0));
    check("hs_in_ready", 64'(in_ready), 64'(1));
    check("hs_busy", 64'(busy), 64'(0));
    check("hs_sum_kept", 64'(sum), 64'(exp_s));
    check("hs_err", 64'(err), 64'(0));
  endtask

  initial begin
    logic [W-1:0] ra, rb, es, es2;
    logic         rc, ec, ec2;
    int           lat, seen;

    rst = 1'b1; in_valid = 1'b1; a = 16'h1111; b = 16'h2222; carry_in = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_carry", 64'(carry_out), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    check("post_rst_busy", 64'(busy), 64'(0));

    op(16'h1234, 16'h5678, 1'b0, 5, 16'h6912, 1'b0, 1'b0);
    op(16'h9999, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0);
    op(16'h0000, 16'h0000, 1'b1, 1, 16'h0001, 1'b0, 1'b0);
    op(16'h00A0, 16'h0001, 1'b0, 2, 16'h0101, 1'b0, CHK);

    // Reset in the second ADD cycle discards the operation.
    wait_ready();
    a = 16'h9999; b = 16'h9999; carry_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_sum", 64'(sum), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_carry", 64'(carry_out), 64'(0));
    seen = 0;
    repeat (DIGITS + 3) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("midrst_no_out_valid", 64'(seen), 64'(0));
    op(16'h0005, 16'h0005, 1'b0, 0, 16'h0010, 1'b0, 1'b0);

    // Back-to-back with out_ready tied high.
    ra = 16'h4821; rb = 16'h3719;
    ref_add(ra, rb, 1'b1, es, ec);
    ref_add(16'h0999, 16'h9001, 1'b0, es2, ec2);
    wait_ready();
    a = ra; b = rb; carry_in = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    a = 16'h0999; b = 16'h9001; carry_in = 1'b0;
    lat = 0;
    while (!out_valid && lat < int'(DIGITS) + 4) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_lat1", 64'(lat), 64'(DIGITS));
    check("b2b_sum1", 64'(sum), 64'(es));
    check("b2b_carry1", 64'(carry_out), 64'(ec));
    @(posedge clk); #1;
    check("b2b_hs_out_valid", 64'(out_valid), 64'(0));
    check("b2b_hs_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    check("b2b_accept2_busy", 64'(busy), 64'(1));
    check("b2b_accept2_in_ready", 64'(in_ready), 64'(0));
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < int'(DIGITS) + 4) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_lat2", 64'(lat), 64'(DIGITS));
    check("b2b_sum2", 64'(sum), 64'(es2));
    check("b2b_carry2", 64'(carry_out), 64'(ec2));
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b_hs2_out_valid", 64'(out_valid), 64'(0));

    // Random valid-BCD operands against the decimal model.
    for (int k = 0; k < 25; k++) begin
      ra = rand_bcd();
      rb = rand_bcd();
      rc = 1'($urandom_range(0, 1));
      ref_add(ra, rb, rc, es, ec);
      op(ra, rb, rc, int'($urandom_range(0, 3)), es, ec, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
